// File: rtl/beat_pkg.sv
// Shared types and helpers for the one-hot beat generator.
package beat_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } beat_state_e;

  // A requested length of 0 or anything above the maximum runs a full-length cycle.
  function automatic int unsigned clamp_len(input int unsigned req, input int unsigned max_beats);
    return ((req == 0) || (req > max_beats)) ? max_beats : req;
  endfunction

endpackage

// File: rtl/beat_decode.sv
// Decodes the active beat index into the one-hot T vector; all-zero when not running.
module beat_decode #(
  parameter int unsigned MAX_BEATS = 4,
  parameter int unsigned LEN_W     = $clog2(MAX_BEATS + 1)
) (
  input  logic                 active,
  input  logic [LEN_W-1:0]     beat_idx,
  output logic [MAX_BEATS-1:0] onehot_c
);

  always_comb begin
    onehot_c = '0;
    for (int i = 0; i < MAX_BEATS; i++) begin
      onehot_c[i] = active && (beat_idx == LEN_W'(i));
    end
  end

endmodule

// File: rtl/beat_generator.sv
// Variable-length one-hot beat generator with hold, run/stop and a completed-cycle counter.
// Optional single-step input enabled by defining BEAT_STEP_EN.
module beat_generator
  import beat_pkg::*;
#(
  parameter  int unsigned MAX_BEATS = 4,
  parameter  int unsigned CNT_W     = 16,
  localparam int unsigned LEN_W     = $clog2(MAX_BEATS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic                 hold,
  input  logic [LEN_W-1:0]     len,
`ifdef BEAT_STEP_EN
  input  logic                 step,
`endif
  output logic [MAX_BEATS-1:0] T,
  output logic [LEN_W-1:0]     beat_idx,
  output logic                 cyc_last,
  output logic [CNT_W-1:0]     cyc_count
);

  beat_state_e      state_q, state_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_clamped;
  logic             start;
  logic             last;

  assign len_clamped = LEN_W'(clamp_len(32'(len), MAX_BEATS));
  assign last        = (state_q == RUN) && (idx_q == LEN_W'(len_q - LEN_W'(1)));

`ifdef BEAT_STEP_EN
  assign start = run || step;
`else
  assign start = run;
`endif

  // Next-state: a started cycle always runs to its last beat; run only decides what follows.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          idx_d   = '0;
          len_d   = len_clamped;
        end
      end
      RUN: begin
        if (!hold) begin
          if (last) begin
            cnt_d = cnt_q + CNT_W'(1);
            idx_d = '0;
            if (run) begin
              len_d = len_clamped;
            end else begin
              state_d = IDLE;
            end
          end else begin
            idx_d = idx_q + LEN_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      len_q   <= LEN_W'(MAX_BEATS);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

  beat_decode #(
    .MAX_BEATS (MAX_BEATS),
    .LEN_W     (LEN_W)
  ) u_decode (
    .active   (state_q == RUN),
    .beat_idx (idx_q),
    .onehot_c (T)
  );

  assign beat_idx  = idx_q;
  assign cyc_last  = last;
  assign cyc_count = cnt_q;

endmodule

// File: tb/tb_beat_generator.sv
// Directed bench for beat_generator with MAX_BEATS=4; step scenario built with BEAT_STEP_EN.
module tb_beat_generator;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        hold;
  logic [2:0]  len;
  logic        step;
  logic [3:0]  T;
  logic [2:0]  beat_idx;
  logic        cyc_last;
  logic [15:0] cyc_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  beat_generator #(
    .MAX_BEATS (4),
    .CNT_W     (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .hold      (hold),
    .len       (len),
`ifdef BEAT_STEP_EN
    .step      (step),
`endif
    .T         (T),
    .beat_idx  (beat_idx),
    .cyc_last  (cyc_last),
    .cyc_count (cyc_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    run  = 1'b0;
    hold = 1'b0;
    step = 1'b0;
    len  = 3'd4;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (T !== 4'b0000 || beat_idx !== 3'd0 || cyc_last !== 1'b0 || cyc_count !== 16'd0) begin
      fails++;
      $display("FAIL reset: T=%b idx=%0d last=%b cnt=%0d, want 0000/0/0/0", T, beat_idx, cyc_last, cyc_count);
    end
  endtask

  task automatic test_len4();
    logic [3:0] exp_t;
    do_reset();
    run = 1'b1;
    len = 3'd4;
    for (int i = 0; i < 5; i++) begin
      tick();
      exp_t = 4'b0001 << (i % 4);
      tests++;
      if (T !== exp_t || beat_idx !== 3'(i % 4) || cyc_last !== (i == 3) ||
          cyc_count !== ((i == 4) ? 16'd1 : 16'd0)) begin
        fails++;
        $display("FAIL len4 beat %0d: T=%b idx=%0d last=%b cnt=%0d, want %b/%0d/%b/%0d",
                 i, T, beat_idx, cyc_last, cyc_count, exp_t, i % 4, (i == 3), (i == 4) ? 1 : 0);
      end
    end
  endtask

  task automatic test_len_change();
    logic [3:0]  exp_t   [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b0001, 4'b0010, 4'b0001};
    logic        exp_l   [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [15:0] exp_c   [6] = '{16'd0, 16'd0, 16'd0, 16'd1, 16'd1, 16'd2};
    do_reset();
    run = 1'b1;
    len = 3'd3;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 1) len = 3'd2;
      tests++;
      if (T !== exp_t[i] || cyc_last !== exp_l[i] || cyc_count !== exp_c[i]) begin
        fails++;
        $display("FAIL len_change step %0d: T=%b last=%b cnt=%0d, want %b/%b/%0d",
                 i, T, cyc_last, cyc_count, exp_t[i], exp_l[i], exp_c[i]);
      end
    end
  endtask

  task automatic test_hold();
    logic [3:0]  exp_t [8] = '{4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b1000, 4'b1000, 4'b0001};
    logic        hld   [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [15:0] exp_c [8] = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd1};
    do_reset();
    hold = 1'b1;
    tick();
    tests++;
    if (T !== 4'b0000) begin
      fails++;
      $display("FAIL hold_idle: T=%b, want 0000", T);
    end
    run = 1'b1;
    tick();
    tests++;
    if (T !== 4'b0001) begin
      fails++;
      $display("FAIL hold_idle_start: T=%b, want 0001", T);
    end
    hold = 1'b0;
    for (int i = 1; i < 8; i++) begin
      tick();
      hold = hld[i];
      tests++;
      if (T !== exp_t[i] || cyc_count !== exp_c[i] || cyc_last !== (exp_t[i] == 4'b1000)) begin
        fails++;
        $display("FAIL hold step %0d: T=%b cnt=%0d last=%b, want %b/%0d/%b",
                 i, T, cyc_count, cyc_last, exp_t[i], exp_c[i], (exp_t[i] == 4'b1000));
      end
    end
  endtask

  task automatic test_run_drop();
    logic [3:0]  exp_t [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000};
    logic [15:0] exp_c [6] = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd1, 16'd1};
    do_reset();
    run = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 1) run = 1'b0;
      tests++;
      if (T !== exp_t[i] || cyc_count !== exp_c[i] || (i >= 4 && (beat_idx !== 3'd0 || cyc_last !== 1'b0))) begin
        fails++;
        $display("FAIL run_drop step %0d: T=%b cnt=%0d idx=%0d last=%b, want %b/%0d",
                 i, T, cyc_count, beat_idx, cyc_last, exp_t[i], exp_c[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    run = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    tests++;
    if (T !== 4'b0100 || cyc_count !== 16'd1) begin
      fails++;
      $display("FAIL reset_mid_pre: T=%b cnt=%0d, want 0100/1", T, cyc_count);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if (T !== 4'b0000 || cyc_count !== 16'd0 || beat_idx !== 3'd0) begin
      fails++;
      $display("FAIL reset_mid: T=%b cnt=%0d idx=%0d, want 0000/0/0", T, cyc_count, beat_idx);
    end
    tick();
    tests++;
    if (T !== 4'b0001) begin
      fails++;
      $display("FAIL reset_mid_restart: T=%b, want 0001", T);
    end
  endtask

  task automatic test_len_clamp();
    logic [2:0] vals [2] = '{3'd0, 3'd7};
    logic [3:0] exp_t;
    for (int v = 0; v < 2; v++) begin
      do_reset();
      len = vals[v];
      run = 1'b1;
      for (int i = 0; i < 5; i++) begin
        tick();
        exp_t = 4'b0001 << (i % 4);
        tests++;
        if (T !== exp_t || cyc_last !== (i == 3) || cyc_count !== ((i == 4) ? 16'd1 : 16'd0)) begin
          fails++;
          $display("FAIL clamp len=%0d beat %0d: T=%b last=%b cnt=%0d, want %b/%b",
                   vals[v], i, T, cyc_last, cyc_count, exp_t, (i == 3));
        end
      end
    end
  endtask

  task automatic test_len1();
    do_reset();
    len = 3'd1;
    run = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (T !== 4'b0001 || cyc_last !== 1'b1 || cyc_count !== 16'(i)) begin
        fails++;
        $display("FAIL len1 clk %0d: T=%b last=%b cnt=%0d, want 0001/1/%0d", i, T, cyc_last, cyc_count, i);
      end
    end
  endtask

`ifdef BEAT_STEP_EN
  task automatic test_step();
    logic [3:0]  exp_t [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000};
    logic        stp   [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [15:0] exp_c [6] = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd1, 16'd1};
    do_reset();
    step = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      step = stp[i];
      tests++;
      if (T !== exp_t[i] || cyc_count !== exp_c[i]) begin
        fails++;
        $display("FAIL step clk %0d: T=%b cnt=%0d, want %b/%0d", i, T, cyc_count, exp_t[i], exp_c[i]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_len4();
    test_len_change();
    test_hold();
    test_run_drop();
    test_reset_mid();
    test_len_clamp();
    test_len1();
`ifdef BEAT_STEP_EN
    test_step();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/beat_generator.md
# beat_generator

Parametrised one-hot beat (timing-phase) generator for the lab CPU control path. Produces a machine cycle of 1..MAX_BEATS one-hot beats on `T`, with a per-cycle length, stall (hold), run/stop control and a completed-cycle counter. It replaces the fixed 4-beat ring counter. The control unit sequences micro-operations directly off `T`.

## Interface
- MAX_BEATS, 4, maximum beats per machine cycle (≥2); width of `T`
- LEN_W, $clog2(MAX_BEATS+1), width of `len` and `beat_idx` (derived, not overridden)
- CNT_W, 16, width of `cyc_count`

- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- run  in  1  level; start / keep issuing machine cycles
- hold  in  1  level; freeze current beat (stall)
- len  in  LEN_W  beats in the next machine cycle; 0 or >MAX_BEATS means MAX_BEATS
- step  in  1  single-step request (present only with BEAT_STEP_EN)
- T  out  MAX_BEATS  one-hot current beat; all-zero when idle
- beat_idx  out  LEN_W  index of the active beat (0 when idle)
- cyc_last  out  1  high during the final beat of the cycle
- cyc_count  out  CNT_W  completed machine cycles, wraps modulo 2^CNT_W

## Operation
- States: IDLE, RUN.
- Reset: state=IDLE, T=0, beat_idx=0, cyc_last=0, cyc_count=0, latched length=MAX_BEATS.
- IDLE: T=0; `hold` ignored. `run`=1 → RUN at beat 0, `len` latched (clamped).
- RUN, hold=1: every register holds; `T`, `beat_idx`, `cyc_last` unchanged.
- RUN, hold=0, not last beat: beat_idx+1, T shifts left by one.
- RUN, hold=0, last beat (beat_idx = latched_len−1): cyc_count+1; if run=1, go to beat 0 and re-latch `len`; else go to IDLE.
- `len` is sampled only on entry to beat 0. Changes mid-cycle affect only the next cycle.
- Dropping `run` never truncates a cycle. The current cycle always completes.
- Length 1: T[0] every clock, and cyc_last stays high continuously.
- cyc_last = RUN && beat_idx == latched_len−1.
- cyc_count wraps from all-ones to 0 without any flag.

## Timing
- All outputs are registered or decoded from registers. There is no combinational path from inputs to outputs.
- run sampled high in IDLE at edge n → T[0]=1 after edge n.
- Each beat lasts exactly 1 clock plus one clock per cycle of asserted `hold`.
- cyc_count updates on the edge that leaves the last beat.
- rst has priority over everything, mid-cycle included: the next state is the reset state.
- A hold during the last beat delays the cycle_count increment and the `len` re-sample.

## Configuration
- BEAT_STEP_EN defined:
  - adds the `step` port.
  - A `step` pulse in IDLE with run=0 executes exactly one machine cycle, then returns to IDLE.
  - `step` is ignored in RUN.
  - If run=1 and step=1 together, run wins (continuous).
  - `hold` still applies during a stepped cycle.
- Not defined: no `step` port, and only `run` starts cycles.

## Structure
- Package `beat_pkg`:
  - state enum typedef (IDLE, RUN)
  - the length-clamp function (0 or >MAX → MAX)
- Sub-module `beat_decode`: combinational beat_idx → one-hot `T`, gated by RUN. It is the only natural split.
- Everything else lives in a single always_ff plus small next-state logic.

## Test plan
All scenarios use MAX_BEATS=4.
- rst 1 clk, then run=1, len=4 → T = 0001,0010,0100,1000,0001; cyc_count=1 after the 4th beat; cyc_last high only with T=1000.
- len=3 at beat 0, len changed to 2 at beat 1 → current cycle 0001,0010,0100; next cycle 0001,0010; cyc_count 1 then 2.
- hold=1 for 2 clocks while T=0010 → T=0010 for 3 clocks, then 0100; cyc_count unaffected until the last beat.
- run dropped during T=0010 → 0100,1000, then T=0000 and beat_idx=0; cyc_count +1.
- rst during T=0100 → next clock T=0000, cyc_count=0; len=0 and len=7 each yield 4-beat cycles.
- BEAT_STEP_EN: run=0, step pulse → one cycle 0001..1000, then IDLE; a second step during that cycle is ignored.
